// File: rtl/stripe_pkg.sv
// Shared definitions for the 2-lane stripe scheduler: FSM states,
// default word width and lane-count encodings.
package stripe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic LANES_1 = 1'b0;
  localparam logic LANES_2 = 1'b1;

endpackage

// File: rtl/stripe_scheduler_lane_out_reg.sv
// Per-lane output stage: registered data word held until the next load,
// plus a single-cycle valid strobe for each loaded word.
module lane_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_i;
      if (load_i) data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/stripe_scheduler.sv
// Round-robin 2-lane word striper with per-lane backpressure; lane-count
// changes take effect only once the current pair is complete.
module stripe_scheduler
  import stripe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              cfg_en,
  input  logic              cfg_lanes,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic              lane_ready0,
  input  logic              lane_ready1,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              next_lane,
  output logic              active_lanes,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             act_q, act_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      act_q   <= LANES_1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  // No lane skipping: readiness is taken only from the lane ptr points at.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_RUN:   in_ready = ptr_q ? lane_ready1 : lane_ready0;
      ST_DRAIN: in_ready = ptr_q & lane_ready1;
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = valid_in & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    act_d   = act_q;
    case (state_q)
      ST_IDLE: begin
        ptr_d = 1'b0;
        if (cfg_en) begin
          state_d = ST_RUN;
          act_d   = cfg_lanes;
        end
      end
      ST_RUN: begin
        if (!cfg_en || (cfg_lanes != act_q)) state_d = ST_DRAIN;
        if (accept) ptr_d = (act_q == LANES_2) ? ~ptr_q : 1'b0;
      end
      ST_DRAIN: begin
        // Pending odd word must land on lane 1 before leaving, so the pair is never torn.
        if (!ptr_q) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          ptr_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lane_out_reg #(.DATA_W(DATA_W)) u_lane0 (
    .clk_i   (clk_2f),
    .reset_i (reset),
    .load_i  (accept & ~ptr_q),
    .data_i  (data_input),
    .data_o  (lane_0),
    .valid_o (valid_out0)
  );

  lane_out_reg #(.DATA_W(DATA_W)) u_lane1 (
    .clk_i   (clk_2f),
    .reset_i (reset),
    .load_i  (accept & ptr_q),
    .data_i  (data_input),
    .data_o  (lane_1),
    .valid_o (valid_out1)
  );

  assign next_lane    = ptr_q;
  assign active_lanes = act_q;
  assign busy         = (state_q != ST_IDLE);
  assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed bench for stripe_scheduler: vector table for streaming/backpressure,
// hand sequences for reconfiguration, disable, mid-stream reset and counter wrap.
module tb_stripe_scheduler;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic        cfg_en, cfg_lanes, valid_in, lane_ready0, lane_ready1;
  logic [31:0] data_input;
  logic        in_ready, valid_out0, valid_out1, next_lane, active_lanes, busy;
  logic [31:0] lane_0, lane_1;
  logic [15:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_2f = ~clk_2f;

  stripe_scheduler #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .cfg_en       (cfg_en),
    .cfg_lanes    (cfg_lanes),
    .data_input   (data_input),
    .valid_in     (valid_in),
    .in_ready     (in_ready),
    .lane_ready0  (lane_ready0),
    .lane_ready1  (lane_ready1),
    .lane_0       (lane_0),
    .lane_1       (lane_1),
    .valid_out0   (valid_out0),
    .valid_out1   (valid_out1),
    .next_lane    (next_lane),
    .active_lanes (active_lanes),
    .busy         (busy),
    .word_cnt     (word_cnt)
  );

  typedef struct {
    logic        en, lanes, vin, lr0, lr1;
    logic [31:0] din;
    logic        e_ir, e_busy, e_nl;          // before the edge
    logic        e_vo0, e_vo1;                // after the edge
    logic [31:0] e_l0, e_l1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic lanes, input logic vin,
                       input logic [31:0] din, input logic lr0, input logic lr1);
    cfg_en = en; cfg_lanes = lanes; valid_in = vin;
    data_input = din; lane_ready0 = lr0; lane_ready1 = lr1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ir"},   in_ready,     0);
    chk({tag, "_l0"},   lane_0,       0);
    chk({tag, "_l1"},   lane_1,       0);
    chk({tag, "_vo0"},  valid_out0,   0);
    chk({tag, "_vo1"},  valid_out1,   0);
    chk({tag, "_nl"},   next_lane,    0);
    chk({tag, "_act"},  active_lanes, 0);
    chk({tag, "_busy"}, busy,         0);
    chk({tag, "_cnt"},  word_cnt,     0);
  endtask

  initial begin
    //        en lanes vin lr0 lr1 din      ir busy nl vo0 vo1 l0     l1     cnt
    vecs[0]  = '{1, 1, 0, 1, 1, 32'h00,  0, 0, 0,  0, 0, 32'h00, 32'h00, 16'd0};
    vecs[1]  = '{1, 1, 1, 1, 1, 32'hA0,  1, 1, 0,  1, 0, 32'hA0, 32'h00, 16'd1};
    vecs[2]  = '{1, 1, 1, 1, 1, 32'hA1,  1, 1, 1,  0, 1, 32'hA0, 32'hA1, 16'd2};
    vecs[3]  = '{1, 1, 1, 1, 1, 32'hA2,  1, 1, 0,  1, 0, 32'hA2, 32'hA1, 16'd3};
    vecs[4]  = '{1, 1, 1, 1, 1, 32'hA3,  1, 1, 1,  0, 1, 32'hA2, 32'hA3, 16'd4};
    vecs[5]  = '{1, 1, 0, 1, 1, 32'h00,  1, 1, 0,  0, 0, 32'hA2, 32'hA3, 16'd4};
    vecs[6]  = '{1, 1, 1, 1, 1, 32'hB0,  1, 1, 0,  1, 0, 32'hB0, 32'hA3, 16'd5};
    vecs[7]  = '{1, 1, 1, 1, 0, 32'hB1,  0, 1, 1,  0, 0, 32'hB0, 32'hA3, 16'd5};
    vecs[8]  = '{1, 1, 1, 1, 0, 32'hB1,  0, 1, 1,  0, 0, 32'hB0, 32'hA3, 16'd5};
    vecs[9]  = '{1, 1, 1, 1, 0, 32'hB1,  0, 1, 1,  0, 0, 32'hB0, 32'hA3, 16'd5};
    vecs[10] = '{1, 1, 1, 1, 1, 32'hB1,  1, 1, 1,  0, 1, 32'hB0, 32'hB1, 16'd6};
    vecs[11] = '{1, 1, 0, 1, 1, 32'h00,  1, 1, 0,  0, 0, 32'hB0, 32'hB1, 16'd6};

    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 0);
    tick(); tick();
    chk_reset_state("rst0");
    reset = 1'b0;

    // Streaming and lane-1 backpressure
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].lanes, vecs[i].vin, vecs[i].din, vecs[i].lr0, vecs[i].lr1);
      chk($sformatf("v%0d_ir", i),   in_ready,  vecs[i].e_ir);
      chk($sformatf("v%0d_busy", i), busy,      vecs[i].e_busy);
      chk($sformatf("v%0d_nl", i),   next_lane, vecs[i].e_nl);
      tick();
      chk($sformatf("v%0d_vo0", i),  valid_out0, vecs[i].e_vo0);
      chk($sformatf("v%0d_vo1", i),  valid_out1, vecs[i].e_vo1);
      chk($sformatf("v%0d_l0", i),   lane_0,     vecs[i].e_l0);
      chk($sformatf("v%0d_l1", i),   lane_1,     vecs[i].e_l1);
      chk($sformatf("v%0d_cnt", i),  word_cnt,   vecs[i].e_cnt);
    end

    // Lane-count change 2 -> 1 while ptr = 1: pending word completes on lane 1
    drive(1, 1, 1, 32'hC0, 1, 1); tick();
    chk("rc_ptr1", next_lane, 1);
    drive(1, 0, 0, 32'h0, 1, 1);
    chk("rc_run_ir", in_ready, 1);
    tick();
    chk("rc_drain_busy", busy, 1);
    chk("rc_drain_act", active_lanes, 1);
    chk("rc_drain_nl", next_lane, 1);
    drive(1, 0, 1, 32'hC1, 1, 1);
    chk("rc_drain_ir", in_ready, 1);
    tick();
    chk("rc_c1_vo1", valid_out1, 1);
    chk("rc_c1_l1", lane_1, 32'hC1);
    chk("rc_c1_vo0", valid_out0, 0);
    chk("rc_idle_busy", busy, 0);
    chk("rc_cnt", word_cnt, 8);
    drive(1, 0, 1, 32'hCC, 1, 1);
    chk("rc_idle_ir", in_ready, 0);
    tick();
    chk("rc_run_act", active_lanes, 0);
    chk("rc_run_busy", busy, 1);
    chk("rc_idle_novo", valid_out0 | valid_out1, 0);
    drive(1, 0, 1, 32'hD0, 1, 1); tick();
    chk("rc_d0_vo0", valid_out0, 1);
    chk("rc_d0_l0", lane_0, 32'hD0);
    chk("rc_d0_nl", next_lane, 0);
    drive(1, 0, 1, 32'hD1, 1, 1); tick();
    chk("rc_d1_vo0", valid_out0, 1);
    chk("rc_d1_vo1", valid_out1, 0);
    chk("rc_d1_l0", lane_0, 32'hD1);
    chk("rc_d1_l1", lane_1, 32'hC1);
    chk("rc_d1_cnt", word_cnt, 10);

    // Disable with ptr = 0: DRAIN then IDLE, nothing accepted
    drive(0, 0, 0, 32'h0, 1, 1);
    chk("dis_run_busy", busy, 1);
    tick();
    chk("dis_drain_busy", busy, 1);
    drive(0, 0, 1, 32'hE0, 1, 1);
    chk("dis_drain_ir", in_ready, 0);
    tick();
    chk("dis_idle_busy", busy, 0);
    chk("dis_novo_a", valid_out0 | valid_out1, 0);
    drive(0, 0, 1, 32'hE1, 1, 1);
    chk("dis_idle_ir", in_ready, 0);
    tick();
    chk("dis_novo_b", valid_out0 | valid_out1, 0);
    chk("dis_cnt", word_cnt, 10);

    // Reset asserted the cycle after an accept, while another word is offered
    drive(1, 1, 0, 32'h0, 1, 1); tick();
    drive(1, 1, 1, 32'hF0, 1, 1); tick();
    chk("rs_f0_vo0", valid_out0, 1);
    chk("rs_f0_cnt", word_cnt, 11);
    reset = 1'b1;
    drive(1, 1, 1, 32'hF1, 1, 1); tick();
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 1, 1);
    chk_reset_state("rst1");

    // Counter wrap: 65535 accepts, then 2 more
    drive(1, 0, 0, 32'h0, 1, 0); tick();
    for (int unsigned n = 0; n < 65535; n++) begin
      drive(1, 0, 1, n, 1, 0);
      tick();
    end
    chk("wrap_ffff", word_cnt, 16'hFFFF);
    drive(1, 0, 1, 32'h1234, 1, 0); tick();
    chk("wrap_0", word_cnt, 0);
    drive(1, 0, 1, 32'h5678, 1, 0); tick();
    chk("wrap_1", word_cnt, 1);
    chk("wrap_l0", lane_0, 32'h5678);
    chk("wrap_l1", lane_1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
